dvp_pattern_gen: RTL and testbench
==================================

DVP_PATTERN_GEN -- requirements
Module: dvp_pattern_gen

Interface
REQ-001 Parameter IMG_W, default 640: active pixels per line.
REQ-002 Parameter IMG_H, default 294: active lines per frame.
REQ-003 Parameter H_BLANK, default 160: hsync-low pixel clocks between active lines (minimum 1).
REQ-004 Parameter V_SYNC, default 3: vsync-high pulse length, in line periods of (IMG_W+H_BLANK) clocks.
REQ-005 Parameter V_BACK, default 17: line periods between vsync fall and the first active line.
REQ-006 Parameter V_FRONT, default 10: line periods after the last active line, before the next vsync or idle.
REQ-007 PixelClk  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 en  in  1  high = stream frames continuously; low = stop after the current frame completes.
REQ-010 pattern  in  2  test-pattern select, sampled once per frame.
REQ-011 pixdata  out  8  pixel value; valid only while hsync=1, 8'd0 otherwise.
REQ-012 hsync  out  1  line-valid (HREF): high for exactly IMG_W consecutive clocks per active line.
REQ-013 vsync  out  1  frame sync, active high, V_SYNC line periods long.
REQ-014 frame_done  out  1  one-clock pulse on the clock after the final V_FRONT clock of each frame.
REQ-015 frame_cnt  out  16  completed-frame counter.

Function
REQ-016 The FSM SHALL have the states IDLE, VS, VBP, ACT, HBL and VFP.
REQ-017 IDLE: all outputs low; en=1 -> VS on the next clock; pattern latched into pat_q on that transition.
REQ-018 VS: vsync=1 for V_SYNC*(IMG_W+H_BLANK) clocks, then -> VBP.
REQ-019 VBP: vsync=0, hsync=0 for V_BACK*(IMG_W+H_BLANK) clocks, then -> ACT with row=0.
REQ-020 ACT: hsync=1 for IMG_W clocks, col 0..IMG_W-1, then -> HBL.
REQ-021 HBL: hsync=0 for H_BLANK clocks; then row++ -> ACT, or -> VFP if row was IMG_H-1.
REQ-022 VFP: lasts V_FRONT*(IMG_W+H_BLANK) clocks.
REQ-023 VFP exit: frame_done pulses, frame_cnt++ (wraps 65535->0), then -> VS (latching pattern) if en=1, else -> IDLE.
REQ-024 Output registers SHALL be driven by state, so hsync, vsync and pixdata change on the same edge and pixdata is aligned with hsync (zero skew).
REQ-025 Pattern 0 (horizontal ramp): pixdata = col[9:2].
REQ-026 Pattern 1 (vertical ramp): pixdata = row[8:1].
REQ-027 Pattern 2 (checkerboard): pixdata = (col[5]^row[5]) ? 8'hFF : 8'h00.
REQ-028 Pattern 3 (moving diagonal): pixdata = (col+row+frame_cnt)[7:0], with addition truncated mod 256.
REQ-029 A pattern input change mid-frame SHALL have no effect until the next VS entry.
REQ-030 Deasserting en mid-frame SHALL complete the frame, including VFP and frame_done, before entering IDLE.
REQ-031 Re-asserting en before VFP exit SHALL keep streaming with no IDLE gap.
REQ-032 Active pixels per frame SHALL equal IMG_W*IMG_H exactly (188160 at defaults); every active line SHALL be contiguous.
REQ-033 Counters: col 10 bits; row 9 bits; blank/line-period counter sized for (IMG_W+H_BLANK)*max(V_SYNC,V_BACK,V_FRONT) with no overflow at defaults.

Reset
REQ-034 While reset=0: state=IDLE; pixdata=0, hsync=0, vsync=0, frame_done=0, frame_cnt=0; col, row, blank counters and pat_q=0.
REQ-035 Reset asserted mid-frame SHALL force all outputs low asynchronously; no partial frame_done.
REQ-036 After reset release with en=1, VS SHALL begin on the first rising edge.

Verification
REQ-037 IMG_W=8, IMG_H=4, H_BLANK=2, V_SYNC=1, V_BACK=1, V_FRONT=1, en=1, pattern=0: vsync high 10 clocks, 10 clocks idle, then 4 bursts of 8 hsync clocks with pixdata 0,0,0,0,1,1,1,1 each, 2-clock gaps; frame_done at clock 70 after VS entry.
REQ-038 Defaults, pattern=2: line 0 pixdata 00 for col 0-31, FF for col 32-63; line 32 inverted; exactly 188160 hsync-high clocks per frame; frame_cnt=1 after first frame_done.
REQ-039 en dropped during row 2 of the small config: remaining rows and VFP complete, one frame_done, then IDLE with all outputs 0; no further vsync.
REQ-040 Pattern changed 0->3 during ACT: current frame keeps ramp; next frame row 0 col 0 = frame_cnt[7:0] (=1).
REQ-041 reset pulsed low during ACT: hsync, vsync and pixdata go to 0 before the next edge, frame_cnt=0; after release a full VS-first frame follows.
REQ-042 Scoreboard bench: stream fed to the camera-capture write path; per-frame write count equals IMG_W*IMG_H; hsync never high while vsync is high.

Source files
------------

// File: rtl/dvp_pattern_gen_if.sv
// DVP video bus: line-valid, frame-sync and pixel byte
// driven by a source toward a capture sink.
interface dvp_pattern_gen_if;
    logic [7:0] pixdata;
    logic       hsync;
    logic       vsync;

    modport master (output pixdata, hsync, vsync);
    modport slave  (input  pixdata, hsync, vsync);
endinterface

// File: rtl/dvp_pattern_gen.sv
// DVP test-pattern source: frame timing FSM plus four
// selectable patterns, all outputs registered together.
module dvp_pattern_gen #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 294,
    parameter int H_BLANK = 160,
    parameter int V_SYNC  = 3,
    parameter int V_BACK  = 17,
    parameter int V_FRONT = 10
) (
    input  logic                PixelClk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          pattern,
    dvp_pattern_gen_if.master   dvp,
    output logic                frame_done,
    output logic [15:0]         frame_cnt
);

    localparam int LINE = IMG_W + H_BLANK;
    localparam int VM1  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int VMAX = (VM1 > V_FRONT) ? VM1 : V_FRONT;
    localparam int CW   = $clog2(LINE * VMAX + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t       VS_END  = cnt_t'(V_SYNC * LINE - 1);
    localparam cnt_t       VB_END  = cnt_t'(V_BACK * LINE - 1);
    localparam cnt_t       VF_END  = cnt_t'(V_FRONT * LINE - 1);
    localparam cnt_t       HB_END  = cnt_t'(H_BLANK - 1);
    localparam logic [9:0] COL_END = 10'(IMG_W - 1);
    localparam logic [8:0] ROW_END = 9'(IMG_H - 1);

    typedef enum logic [2:0] {
        IDLE, VS, VBP, ACT, HBL, VFP
    } state_t;

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic [1:0]  pat_q, pat_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        done_q, done_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [7:0]  pix_q, pix_d;
    logic [7:0]  diag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        col_d   = col_q;
        row_d   = row_q;
        pat_d   = pat_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = VS;
                    pat_d   = pattern;
                end
            end
            VS: if (cnt_q == VS_END) begin
                state_d = VBP;
                cnt_d   = '0;
            end
            VBP: if (cnt_q == VB_END) begin
                state_d = ACT;
                cnt_d   = '0;
                col_d   = '0;
                row_d   = '0;
            end
            ACT: begin
                cnt_d = '0;
                col_d = col_q + 1'b1;
                if (col_q == COL_END) begin
                    state_d = HBL;
                    col_d   = '0;
                end
            end
            HBL: if (cnt_q == HB_END) begin
                cnt_d = '0;
                if (row_q == ROW_END) begin
                    state_d = VFP;
                end else begin
                    state_d = ACT;
                    row_d   = row_q + 1'b1;
                end
            end
            VFP: if (cnt_q == VF_END) begin
                cnt_d  = '0;
                done_d = 1'b1;
                fcnt_d = fcnt_q + 16'd1;
                if (en) begin
                    state_d = VS;
                    pat_d   = pattern;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs derive from next-state values so they all
        // switch on the same edge as the state register.
        hs_d = (state_d == ACT);
        vs_d = (state_d == VS);
        diag = col_d[7:0] + row_d[7:0] + fcnt_d[7:0];
        unique case (pat_d)
            2'd0: pix_d = col_d[9:2];
            2'd1: pix_d = row_d[8:1];
            2'd2: pix_d = {8{col_d[5] ^ row_d[5]}};
            2'd3: pix_d = diag;
        endcase
        if (!hs_d) pix_d = 8'd0;
    end

    always_ff @(posedge PixelClk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pat_q   <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            pix_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            pix_q   <= pix_d;
        end
    end

    assign dvp.pixdata = pix_q;
    assign dvp.hsync   = hs_q;
    assign dvp.vsync   = vs_q;
    assign frame_done  = done_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Directed bench: small-geometry timing/pattern scenarios
// and a medium-geometry checkerboard frame.
module tb_dvp_pattern_gen;

    logic        clk;
    logic        rst_n, en;
    logic [1:0]  pattern;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        rst1_n, en1;
    logic [1:0]  pattern1;
    logic        fd1;
    logic [15:0] fc1;
    int          total, bad;

    dvp_pattern_gen_if d0 ();
    dvp_pattern_gen_if d1 ();

    dvp_pattern_gen #(
        .IMG_W(8), .IMG_H(4), .H_BLANK(2),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
    ) u0 (
        .PixelClk(clk), .reset(rst_n), .en(en),
        .pattern(pattern), .dvp(d0),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    dvp_pattern_gen #(
        .IMG_W(64), .IMG_H(40), .H_BLANK(4),
        .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
    ) u1 (
        .PixelClk(clk), .reset(rst1_n), .en(en1),
        .pattern(pattern1), .dvp(d1),
        .frame_done(fd1), .frame_cnt(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {vsync,hsync,pixdata} of the 8x4 geometry
    // (line period 10) at a clock offset from VS entry.
    function automatic logic [9:0] exp_s(int rel, int pat, int fc);
        int a, c, r;
        logic vs, hs;
        logic [7:0] p;
        vs = (rel < 10);
        hs = 1'b0;
        p  = 8'd0;
        a  = rel - 20;
        if (a >= 0 && a < 40) begin
            r  = a / 10;
            c  = a % 10;
            hs = (c < 8);
            if (hs) begin
                case (pat)
                    0: p = 8'(c >> 2);
                    1: p = 8'(r >> 1);
                    2: p = ((((c >> 5) ^ (r >> 5)) & 1) != 0) ? 8'hFF : 8'h00;
                    default: p = 8'(c + r + fc);
                endcase
            end
        end
        return {vs, hs, p};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst1_n = 1'b0;
        en = 1'b0; pattern = 2'd0;
        en1 = 1'b1; pattern1 = 2'd2;
        repeat (3) step();
        total++;
        if ({d0.vsync, d0.hsync, d0.pixdata} !== 10'd0) begin
            bad++;
            $display("FAIL rst_outs got=%h exp=000",
                     {d0.vsync, d0.hsync, d0.pixdata});
        end
        total++;
        if (frame_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_done got=%b exp=0", frame_done);
        end
        total++;
        if (frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_cnt got=%0d exp=0", frame_cnt);
        end
        total++;
        if ({d1.vsync, d1.hsync, fd1} !== 3'd0) begin
            bad++;
            $display("FAIL rst_u1 got=%b exp=000", {d1.vsync, d1.hsync, fd1});
        end
    endtask

    task automatic test_first_frame;
        logic [9:0] e;
        @(negedge clk);
        en = 1'b1;
        rst_n = 1'b1;
        for (int rel = 0; rel < 70; rel++) begin
            step();
            e = exp_s(rel, 0, 0);
            total++;
            if ({d0.vsync, d0.hsync, d0.pixdata} !== e) begin
                bad++;
                $display("FAIL f1_outs rel=%0d got=%h exp=%h", rel,
                         {d0.vsync, d0.hsync, d0.pixdata}, e);
            end
            total++;
            if (frame_done !== 1'b0) begin
                bad++;
                $display("FAIL f1_done rel=%0d got=%b exp=0", rel, frame_done);
            end
            if (rel == 25) pattern = 2'd3;
        end
    endtask

    task automatic test_en_reassert;
        logic [9:0] e;
        for (int rel = 0; rel < 70; rel++) begin
            step();
            e = exp_s(rel, 3, 1);
            total++;
            if ({d0.vsync, d0.hsync, d0.pixdata} !== e) begin
                bad++;
                $display("FAIL f2_outs rel=%0d got=%h exp=%h", rel,
                         {d0.vsync, d0.hsync, d0.pixdata}, e);
            end
            total++;
            if (frame_done !== 1'(rel == 0)) begin
                bad++;
                $display("FAIL f2_done rel=%0d got=%b", rel, frame_done);
            end
            if (rel == 0) begin
                total++;
                if (frame_cnt !== 16'd1) begin
                    bad++;
                    $display("FAIL f2_cnt got=%0d exp=1", frame_cnt);
                end
            end
            if (rel == 42) en = 1'b0;
            if (rel == 65) en = 1'b1;
        end
    endtask

    task automatic test_en_drop;
        logic [9:0] e;
        for (int rel = 0; rel < 90; rel++) begin
            step();
            e = (rel < 70) ? exp_s(rel, 3, 2) : 10'd0;
            total++;
            if ({d0.vsync, d0.hsync, d0.pixdata} !== e) begin
                bad++;
                $display("FAIL f3_outs rel=%0d got=%h exp=%h", rel,
                         {d0.vsync, d0.hsync, d0.pixdata}, e);
            end
            total++;
            if (frame_done !== 1'(rel == 0 || rel == 70)) begin
                bad++;
                $display("FAIL f3_done rel=%0d got=%b", rel, frame_done);
            end
            if (rel == 0 || rel == 89) begin
                total++;
                if (frame_cnt !== ((rel == 0) ? 16'd2 : 16'd3)) begin
                    bad++;
                    $display("FAIL f3_cnt rel=%0d got=%0d", rel, frame_cnt);
                end
            end
            if (rel == 42) en = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] e;
        en = 1'b1;
        for (int rel = 0; rel < 25; rel++) begin
            step();
            e = exp_s(rel, 3, 3);
            total++;
            if ({d0.vsync, d0.hsync, d0.pixdata} !== e) begin
                bad++;
                $display("FAIL f4_outs rel=%0d got=%h exp=%h", rel,
                         {d0.vsync, d0.hsync, d0.pixdata}, e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({d0.vsync, d0.hsync, d0.pixdata} !== 10'd0) begin
            bad++;
            $display("FAIL arst_outs got=%h exp=000",
                     {d0.vsync, d0.hsync, d0.pixdata});
        end
        total++;
        if ({frame_done, frame_cnt} !== 17'd0) begin
            bad++;
            $display("FAIL arst_cnt got=%0d/%b exp=0/0", frame_cnt, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int rel = 0; rel < 70; rel++) begin
            step();
            e = exp_s(rel, 3, 0);
            total++;
            if ({d0.vsync, d0.hsync, d0.pixdata} !== e) begin
                bad++;
                $display("FAIL f5_outs rel=%0d got=%h exp=%h", rel,
                         {d0.vsync, d0.hsync, d0.pixdata}, e);
            end
            total++;
            if (frame_done !== 1'b0) begin
                bad++;
                $display("FAIL f5_done rel=%0d got=%b exp=0", rel, frame_done);
            end
        end
        step();
        total++;
        if ({frame_done, d0.vsync, frame_cnt} !== {2'b11, 16'd1}) begin
            bad++;
            $display("FAIL f5_end got=%b%b/%0d exp=11/1",
                     frame_done, d0.vsync, frame_cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_checker;
        int hcnt, ovl, dcnt, col;
        logic [7:0] ex;
        hcnt = 0; ovl = 0; dcnt = 0;
        @(negedge clk);
        rst1_n = 1'b1;
        for (int rel = 0; rel <= 2924; rel++) begin
            step();
            if (d1.hsync === 1'b1) hcnt++;
            if (d1.hsync === 1'b1 && d1.vsync === 1'b1) ovl++;
            if (fd1 === 1'b1) dcnt++;
            if (rel >= 136 && rel < 200) begin
                col = rel - 136;
                ex = (col >= 32) ? 8'hFF : 8'h00;
                total++;
                if ({d1.hsync, d1.pixdata} !== {1'b1, ex}) begin
                    bad++;
                    $display("FAIL chk_l0 col=%0d got=%b/%h exp=1/%h",
                             col, d1.hsync, d1.pixdata, ex);
                end
            end
            if (rel >= 2312 && rel < 2376) begin
                col = rel - 2312;
                ex = (col >= 32) ? 8'h00 : 8'hFF;
                total++;
                if ({d1.hsync, d1.pixdata} !== {1'b1, ex}) begin
                    bad++;
                    $display("FAIL chk_l32 col=%0d got=%b/%h exp=1/%h",
                             col, d1.hsync, d1.pixdata, ex);
                end
            end
            if (rel == 1000) en1 = 1'b0;
        end
        total++;
        if (hcnt != 2560) begin
            bad++;
            $display("FAIL chk_pixcount got=%0d exp=2560", hcnt);
        end
        total++;
        if (ovl != 0) begin
            bad++;
            $display("FAIL chk_overlap got=%0d exp=0", ovl);
        end
        total++;
        if (dcnt != 1 || fd1 !== 1'b1) begin
            bad++;
            $display("FAIL chk_done got=%0d/%b exp=1/1", dcnt, fd1);
        end
        total++;
        if (fc1 !== 16'd1 || d1.vsync !== 1'b0) begin
            bad++;
            $display("FAIL chk_cnt got=%0d/%b exp=1/0", fc1, d1.vsync);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_first_frame();
        test_en_reassert();
        test_en_drop();
        test_reset_mid();
        test_checker();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
